// File: rtl/img_pkg.sv
`default_nettype none
// ============================================================================
// Module      : img_pkg
// Description : Shared types and constants for the image receive/transmit path.
// Revision    : 1.0 - initial release
// ============================================================================
package img_pkg;

    localparam int BYTE_W             = 8;
    localparam int IMG_PIXELS_DEFAULT = 16384;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RECEIVING = 2'd1,
        DONE      = 2'd2
    } rx_state_t;

endpackage : img_pkg
`default_nettype wire

// File: rtl/recv_img_if.sv
`default_nettype none
// ============================================================================
// Module      : recv_img_if
// Description : Image BRAM write port bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface recv_img_if #(
    parameter int ADDR_W = 14
);
    import img_pkg::*;

    logic [ADDR_W-1:0] bram_addr;
    logic [BYTE_W-1:0] bram_din;
    logic              bram_we;

    modport master (output bram_addr, output bram_din, output bram_we);
    modport slave  (input  bram_addr, input  bram_din, input  bram_we);

endinterface : recv_img_if
`default_nettype wire

// File: rtl/recv_img_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver, synchronised input, mid-bit sampling.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import img_pkg::*;
#(
    parameter int CLOCKS_PER_BAUD = 50
) (
    input  wire logic              clk,
    input  wire logic              rst_in,
    input  wire logic              rx,
    output logic [BYTE_W-1:0]      data_o,
    output logic                   byte_valid,
    output logic                   frame_err
);

    localparam int c_cnt_w = (CLOCKS_PER_BAUD > 1) ? $clog2(CLOCKS_PER_BAUD) : 1;
    localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(CLOCKS_PER_BAUD - 1);
    localparam logic [c_cnt_w-1:0] c_half = c_cnt_w'(CLOCKS_PER_BAUD / 2 - 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_start = 2'd1;
    localparam logic [1:0] c_st_data  = 2'd2;
    localparam logic [1:0] c_st_stop  = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_next;
    logic [2:0]        r_sync;
    logic [c_cnt_w-1:0] r_baud;
    logic [2:0]        r_bit;
    logic [BYTE_W-1:0] r_shift;
    logic              w_rx;
    logic              w_rx_prev;
    logic              w_tick;

    // Third stage gives edge detection so a low line after a bad stop bit is not taken as a start.
    assign w_rx      = r_sync[1];
    assign w_rx_prev = r_sync[2];
    assign w_tick    = (r_state == c_st_start) ? (r_baud == c_half) : (r_baud == c_full);

    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle:  if (w_rx_prev && !w_rx) w_next = c_st_start;
            c_st_start: if (w_tick) w_next = w_rx ? c_st_idle : c_st_data;
            c_st_data:  if (w_tick && (r_bit == 3'd7)) w_next = c_st_stop;
            c_st_stop:  if (w_tick) w_next = c_st_idle;
            default:    w_next = c_st_idle;
        endcase
    end

    always_comb begin
        data_o     = r_shift;
        byte_valid = (r_state == c_st_stop) && w_tick && w_rx;
        frame_err  = (r_state == c_st_stop) && w_tick && !w_rx;
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_sync  <= 3'b111;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_sync <= {r_sync[1:0], rx};
            if ((r_state == c_st_idle) || w_tick) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + 1'b1;
            end
            if (r_state == c_st_idle) begin
                r_bit <= '0;
            end else if ((r_state == c_st_data) && w_tick) begin
                r_bit   <= r_bit + 1'b1;
                r_shift <= {w_rx, r_shift[BYTE_W-1:1]};
            end
        end
    end

endmodule : uart_rx
`default_nettype wire

// File: rtl/recv_img.sv
`default_nettype none
// ============================================================================
// Module      : recv_img
// Description : UART image loader writing one byte per pixel into image BRAM.
// Revision    : 1.0 - initial release
// ============================================================================
module recv_img
    import img_pkg::*;
#(
    parameter int CLOCKS_PER_BAUD = 50,
    parameter int IMG_PIXELS      = IMG_PIXELS_DEFAULT,
    parameter int ADDR_W          = 14,
    parameter int TIMEOUT_CYCLES  = 50000
) (
    input  wire logic   clk,
    input  wire logic   rst_in,
    input  wire logic   rx,
    input  wire logic   send_busy,
    recv_img_if.master  bram,
    output logic        full_image_received,
    output logic        busy,
    output logic [1:0]  out_state,
    output logic        timeout,
    output logic        rx_err
);

    localparam int c_tcnt_w = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ADDR_W:0]     c_last_idx = (ADDR_W + 1)'(IMG_PIXELS - 1);
    localparam logic [c_tcnt_w-1:0] c_tmo_last = c_tcnt_w'(TIMEOUT_CYCLES - 1);

    rx_state_t           r_state;
    rx_state_t           w_next;
    logic [BYTE_W-1:0]   w_byte;
    logic                w_byte_valid;
    logic                w_frame_err;
    logic                w_accept;
    logic                w_tmo_hit;
    logic [ADDR_W:0]     r_count;
    logic [c_tcnt_w-1:0] r_tcnt;
    logic                r_last;
    logic [ADDR_W-1:0]   r_addr;
    logic [BYTE_W-1:0]   r_din;
    logic                r_we;
    logic                r_timeout;
    logic                r_rx_err;

    uart_rx #(
        .CLOCKS_PER_BAUD (CLOCKS_PER_BAUD)
    ) u_uart_rx (
        .clk        (clk),
        .rst_in     (rst_in),
        .rx         (rx),
        .data_o     (w_byte),
        .byte_valid (w_byte_valid),
        .frame_err  (w_frame_err)
    );

    // r_last marks the cycle the final pixel is on the BRAM port; DONE follows it.
    assign w_accept  = w_byte_valid && !send_busy && (r_state != DONE) && !r_last;
    assign w_tmo_hit = (r_state == RECEIVING) && !r_last && !w_accept && (r_tcnt == c_tmo_last);

    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (w_accept) w_next = RECEIVING;
            RECEIVING: begin
                if (r_last) begin
                    w_next = DONE;
                end else if (w_tmo_hit) begin
                    w_next = IDLE;
                end
            end
            DONE:      w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_comb begin
        full_image_received = (r_state == DONE);
        busy                = (r_state != IDLE);
        out_state           = r_state;
        timeout             = r_timeout;
        rx_err              = r_rx_err;
        bram.bram_addr      = r_addr;
        bram.bram_din       = r_din;
        bram.bram_we        = r_we;
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_count   <= '0;
            r_tcnt    <= '0;
            r_last    <= 1'b0;
            r_addr    <= '0;
            r_din     <= '0;
            r_we      <= 1'b0;
            r_timeout <= 1'b0;
            r_rx_err  <= 1'b0;
        end else begin
            r_we      <= w_accept;
            r_rx_err  <= w_frame_err;
            r_timeout <= w_tmo_hit;
            r_last    <= w_accept && (r_count == c_last_idx);
            if (w_accept) begin
                r_addr  <= r_count[ADDR_W-1:0];
                r_din   <= w_byte;
                r_count <= r_count + 1'b1;
            end
            if ((w_next == IDLE) && (r_state != IDLE)) begin
                r_count <= '0;
                r_addr  <= '0;
            end
            if ((r_state == RECEIVING) && !w_accept && !w_tmo_hit) begin
                r_tcnt <= r_tcnt + 1'b1;
            end else begin
                r_tcnt <= '0;
            end
        end
    end

endmodule : recv_img
`default_nettype wire

// File: tb/tb_recv_img.sv
`default_nettype none
// ============================================================================
// Module      : tb_recv_img
// Description : Scoreboard bench for recv_img driving serial frames on rx.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_recv_img;

    localparam int CPB  = 50;
    localparam int PIX  = 16;
    localparam int AW   = 4;
    localparam int TMO  = 2000;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    data;
        bit            last;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst_in;
    logic       rx;
    logic       send_busy;
    logic       full_image_received;
    logic       busy;
    logic [1:0] out_state;
    logic       timeout;
    logic       rx_err;

    recv_img_if #(.ADDR_W(AW)) bram_if ();

    recv_img #(
        .CLOCKS_PER_BAUD (CPB),
        .IMG_PIXELS      (PIX),
        .ADDR_W          (AW),
        .TIMEOUT_CYCLES  (TMO)
    ) dut (
        .clk                 (clk),
        .rst_in              (rst_in),
        .rx                  (rx),
        .send_busy           (send_busy),
        .bram                (bram_if.master),
        .full_image_received (full_image_received),
        .busy                (busy),
        .out_state           (out_state),
        .timeout             (timeout),
        .rx_err              (rx_err)
    );

    always #5 clk = ~clk;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  n_full   = 0;
    int  n_tmo    = 0;
    int  n_err    = 0;
    bit  exp_full_next = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every write and checks the frame pulse timing.
    always @(negedge clk) begin
        wr_t e;
        if (!rst_in) begin
            if (exp_full_next) begin
                check("full_pulse", {31'd0, full_image_received}, 32'd1);
                check("done_state", {30'd0, out_state}, 32'd2);
                exp_full_next = 1'b0;
            end else if (full_image_received) begin
                check("spurious_full", {31'd0, full_image_received}, 32'd0);
            end
            if (full_image_received) n_full++;
            if (timeout) n_tmo++;
            if (rx_err) n_err++;
            if (bram_if.bram_we) begin
                if (exp_q.size() == 0) begin
                    check("spurious_write", {31'd0, bram_if.bram_we}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", {28'd0, bram_if.bram_addr}, {28'd0, e.addr});
                    check("wr_data", {24'd0, bram_if.bram_din}, {24'd0, e.data});
                    exp_full_next = e.last;
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit stop);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        if (!stop) repeat (CPB) @(negedge clk);
    endtask

    task automatic send_exp(input logic [7:0] b, input logic [AW-1:0] a, input bit last);
        wr_t e;
        e.addr = a;
        e.data = b;
        e.last = last;
        exp_q.push_back(e);
        send_byte(b, 1'b1);
    endtask

    task automatic settle();
        repeat (20) @(negedge clk);
        check("queue_empty", exp_q.size(), 32'd0);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_state"}, {30'd0, out_state}, 32'd0);
        check({tag, "_we"}, {31'd0, bram_if.bram_we}, 32'd0);
        check({tag, "_addr"}, {28'd0, bram_if.bram_addr}, 32'd0);
        check({tag, "_full"}, {31'd0, full_image_received}, 32'd0);
    endtask

    initial begin
        rst_in    = 1'b1;
        rx        = 1'b1;
        send_busy = 1'b0;
        repeat (3) @(negedge clk);
        check_quiet("reset");
        check("reset_din", {24'd0, bram_if.bram_din}, 32'd0);
        check("reset_tmo", {31'd0, timeout}, 32'd0);
        check("reset_err", {31'd0, rx_err}, 32'd0);
        rst_in = 1'b0;
        repeat (5) @(negedge clk);

        // 1: full frame 0x00..0x0F
        for (int i = 0; i < PIX; i++) send_exp(8'(i), AW'(i), i == PIX - 1);
        settle();
        check_quiet("t1_after");
        check("t1_full_cnt", n_full, 32'd1);

        // 2: stalled sender, then a complete frame from address 0
        for (int i = 0; i < 5; i++) send_exp(8'hB0 + 8'(i), AW'(i), 1'b0);
        repeat (TMO + 100) @(negedge clk);
        check("t2_tmo_cnt", n_tmo, 32'd1);
        check("t2_full_cnt", n_full, 32'd1);
        check_quiet("t2_after_tmo");
        for (int i = 0; i < PIX; i++) send_exp(8'hF0 ^ 8'(i), AW'(i), i == PIX - 1);
        settle();
        check("t2_full_cnt2", n_full, 32'd2);

        // 3: byte dropped while transmit stage busy
        send_busy = 1'b1;
        send_byte(8'hA5, 1'b1);
        send_busy = 1'b0;
        repeat (5) @(negedge clk);
        check("t3_state_idle", {30'd0, out_state}, 32'd0);
        send_exp(8'h3C, 4'd0, 1'b0);
        settle();
        check("t3_state_recv", {30'd0, out_state}, 32'd1);
        repeat (TMO + 100) @(negedge clk);
        check("t3_tmo_cnt", n_tmo, 32'd2);

        // 4: framing error on the fourth byte
        send_exp(8'h10, 4'd0, 1'b0);
        send_exp(8'h11, 4'd1, 1'b0);
        send_exp(8'h12, 4'd2, 1'b0);
        send_byte(8'h13, 1'b0);
        check("t4_err_cnt", n_err, 32'd1);
        send_exp(8'h77, 4'd3, 1'b0);
        for (int i = 4; i < PIX; i++) send_exp(8'h80 + 8'(i), AW'(i), i == PIX - 1);
        settle();
        check("t4_full_cnt", n_full, 32'd3);

        // 5: reset after the eighth write
        for (int i = 0; i < 8; i++) send_exp(8'h55 ^ 8'(i), AW'(i), 1'b0);
        repeat (5) @(negedge clk);
        rst_in = 1'b1;
        @(negedge clk);
        check_quiet("t5_reset");
        rst_in = 1'b0;
        for (int i = 0; i < PIX; i++) send_exp(8'h20 + 8'(i), AW'(i), i == PIX - 1);
        settle();
        check("t5_full_cnt", n_full, 32'd4);

        // 6: two frames back to back
        for (int i = 0; i < 2 * PIX; i++) send_exp(8'hC0 + 8'(i), AW'(i % PIX), (i % PIX) == PIX - 1);
        settle();
        check("t6_full_cnt", n_full, 32'd6);
        check("final_tmo_cnt", n_tmo, 32'd2);
        check("final_err_cnt", n_err, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_recv_img
`default_nettype wire
